// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Brief    : Fetch-stage program counter with boot hold, fetch stall,
//             trap redirection, misaligned-target detection with exception
//             PC capture, and a retired-fetch counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                INC          = 4,
    parameter int                ALIGN_BITS   = 2,
    parameter int                BOOT_DELAY   = 1,
    parameter int                CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic                 jalr,
    input  logic [WIDTH-1:0]     immediate,
    input  logic [WIDTH-1:0]     jump_target,
    input  logic                 trap_req,
    input  logic [WIDTH-1:0]     trap_vector,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_next_seq,
    output logic                 pc_valid,
    output logic                 misaligned,
    output logic [WIDTH-1:0]     epc,
    output logic [CNT_WIDTH-1:0] retired_count
);

    // Boot counter only needs to reach BOOT_DELAY-1.
    localparam int C_BOOT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [C_BOOT_W-1:0] C_BOOT_LAST = C_BOOT_W'(BOOT_DELAY - 1);

    // Bits of a target that must be zero, and the jalr bit-0 clear mask.
    localparam logic [WIDTH-1:0] C_ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);
    localparam logic [WIDTH-1:0] C_CLR_BIT0   = {{(WIDTH-1){1'b1}}, 1'b0};

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;

    logic [1:0]           r_state_q,    w_state_d;
    logic [WIDTH-1:0]     r_pc_q,       w_pc_d;
    logic [WIDTH-1:0]     r_epc_q,      w_epc_d;
    logic                 r_mis_q,      w_mis_d;
    logic                 r_valid_q,    w_valid_d;
    logic [CNT_WIDTH-1:0] r_cnt_q,      w_cnt_d;
    logic [C_BOOT_W-1:0]  r_boot_q,     w_boot_d;

    logic [WIDTH-1:0]     w_target;
    logic                 w_target_ok;

    // Redirect target: jalr has priority over the PC-relative branch.
    always_comb begin
        w_target    = jalr ? (jump_target & C_CLR_BIT0) : (r_pc_q + immediate);
        w_target_ok = ((w_target & C_ALIGN_MASK) == '0);
    end

    // Next-state and next-PC selection for BOOT / RUN / TRAP.
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_epc_d   = r_epc_q;
        w_mis_d   = 1'b0;
        w_cnt_d   = r_cnt_q;
        w_boot_d  = r_boot_q;
        case (r_state_q)
            S_BOOT: begin
                w_boot_d = r_boot_q + C_BOOT_W'(1);
                if (r_boot_q == C_BOOT_LAST) begin
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (trap_req) begin
                    // External trap wins even over a stall; pc holds.
                    w_epc_d   = r_pc_q;
                    w_state_d = S_TRAP;
                end else if (stall) begin
                    w_state_d = S_RUN;
                end else if (jalr || pc_src) begin
                    if (w_target_ok) begin
                        w_pc_d  = w_target;
                        w_cnt_d = r_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        w_epc_d   = w_target;
                        w_mis_d   = 1'b1;
                        w_state_d = S_TRAP;
                    end
                end else begin
                    w_pc_d  = r_pc_q + WIDTH'(INC);
                    w_cnt_d = r_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_TRAP: begin
                w_pc_d    = trap_vector & ~C_ALIGN_MASK;
                w_state_d = S_RUN;
            end
            default: begin
                w_state_d = S_BOOT;
            end
        endcase
        w_valid_d = (w_state_d == S_RUN);
    end

    // State registers; reset overrides every state including TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_BOOT;
            r_pc_q    <= RESET_VECTOR;
            r_epc_q   <= '0;
            r_mis_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_cnt_q   <= '0;
            r_boot_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_epc_q   <= w_epc_d;
            r_mis_q   <= w_mis_d;
            r_valid_q <= w_valid_d;
            r_cnt_q   <= w_cnt_d;
            r_boot_q  <= w_boot_d;
        end
    end

    assign pc            = r_pc_q;
    assign pc_next_seq   = r_pc_q + WIDTH'(INC);
    assign pc_valid      = r_valid_q;
    assign misaligned    = r_mis_q;
    assign epc           = r_epc_q;
    assign retired_count = r_cnt_q;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the single-issue core. It generalises the fixed 32-bit PC: width, reset vector, increment and alignment are parameters, and it adds a fetch stall, a post-reset boot hold, trap redirection, misaligned-target detection with an exception PC, and a retired-fetch counter. It drives instruction-memory addressing and feeds the link value to the register-file write path.

## Interface
- WIDTH, 32: PC, target and immediate width in bits.
- RESET_VECTOR, 0: PC value loaded by reset.
- INC, 4: sequential increment in bytes.
- ALIGN_BITS, 2: low target bits that must be zero. Use 1 for compressed-instruction builds.
- BOOT_DELAY, 1: cycles spent in BOOT after reset deasserts. Must be ≥1.
- CNT_WIDTH, 32: width of retired_count.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; ignored outside RUN.
- pc_src  in  1  PC-relative branch/jal taken: target = pc + immediate.
- jalr  in  1  register-indirect jump: target = jump_target with bit 0 cleared.
- immediate  in  WIDTH  signed branch offset.
- jump_target  in  WIDTH  jalr target (rs1 + imm, computed upstream).
- trap_req  in  1  external trap/exception request.
- trap_vector  in  WIDTH  trap handler address.
- pc  out  WIDTH  current fetch address (registered).
- pc_next_seq  out  WIDTH  pc + INC (combinational; link value).
- pc_valid  out  1  pc is a fetch address to issue this cycle.
- misaligned  out  1  one-cycle flag: a jump target failed alignment.
- epc  out  WIDTH  exception PC (registered).
- retired_count  out  CNT_WIDTH  count of PC advances.

## Operation
- States: BOOT, RUN, TRAP.
- Reset (clk edge with reset=1; overrides all other inputs in every state):
  - state=BOOT, pc=RESET_VECTOR, epc=0, misaligned=0, retired_count=0, boot counter=0.
  - pc_valid=0 while in BOOT.
- BOOT: pc holds and the boot counter increments. After BOOT_DELAY cycles the state goes to RUN; pc is unchanged.
- RUN: pc_valid=1. Next-PC priority on each edge:
  1. trap_req=1 (acts even if stall=1): epc←pc, state→TRAP, pc holds.
  2. stall=1: everything holds.
  3. jalr=1: target = jump_target & ~1.
  4. pc_src=1: target = pc + immediate, modulo 2^WIDTH.
  5. Otherwise: pc←pc+INC, modulo 2^WIDTH.
- Cases 3 and 4 commit the target to pc only if its low ALIGN_BITS bits are zero. Otherwise: pc holds, epc←target, misaligned←1, state→TRAP.
- retired_count increments by 1 on every RUN edge that updates pc. It wraps at 2^CNT_WIDTH.
- TRAP: exactly one cycle, pc_valid=0, stall ignored. Next edge:
  - pc←trap_vector with low ALIGN_BITS bits cleared.
  - misaligned←0, state→RUN.
  - retired_count unchanged.
- jalr and pc_src together: jalr wins and immediate is ignored.
- pc_next_seq always equals pc+INC, including in BOOT and TRAP.

## Timing
- pc, pc_valid, misaligned, epc, retired_count are all registered. Redirect latency is 1 edge.
- First pc_valid=1 cycle falls BOOT_DELAY cycles after the first edge with reset=0, with pc=RESET_VECTOR.
- Misaligned or trap_req event: detecting edge → TRAP (1 cycle, pc_valid=0, pc=old value) → next edge pc=trap_vector. The penalty is exactly 1 bubble.
- misaligned is high only during the TRAP cycle caused by alignment. trap_req-initiated TRAP leaves it 0.
- Reset asserted during TRAP or BOOT takes effect at the same edge; no trap redirect follows.

## Test plan
- Defaults: reset high 2 edges, then low. Required: pc=0 and pc_valid=0 for 1 cycle, then pc_valid=1. After 3 more edges pc=12 and retired_count=3.
- At pc=12, pc_src=1 with immediate=20 for 1 edge → pc=32. Two sequential edges → pc=40, retired_count=6.
- At pc=40, jalr=1, jump_target=101, and simultaneously pc_src=1, immediate=8 → pc=100 (jalr wins, bit 0 cleared). Then stall for 3 edges → pc=100 and count unchanged.
- At pc=100, pc_src=1 with immediate=6, trap_vector=0x202:
  - misaligned=1, epc=106, pc=100, pc_valid=0 for 1 cycle.
  - Then pc=0x200, misaligned=0.
- At pc=0x204 with stall=1, trap_req=1 → epc=0x204, one TRAP cycle, then pc=trap_vector. retired_count does not change on either edge.
- Reset asserted during a TRAP cycle:
  - Next cycle pc=0, pc_valid=0, misaligned=0, retired_count=0.
  - No trap_vector load occurs.
